vx_sfu_csr_responder: RTL

Slave-side CSR bank for an SFU extension (tex, raster or rop). Terminates the `VX_sfu_csr_if` requests that the core CSR unit issues for one extension address window. Holds a per-warp shadow bank that software writes and reads back, plus a per-warp active bank that the extension datapath consumes. Shadow is copied into active on a software commit, deferred while the datapath holds that warp's state locked.

---
 rtl/vx_sfu_csr_pkg.sv | 39 +++
 rtl/vx_sfu_csr_bank.sv | 80 ++++++++
 rtl/vx_sfu_csr_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vx_sfu_csr_pkg.sv
// Shared constants and types for the SFU extension CSR responder.
package vx_sfu_csr_pkg;

  localparam int unsigned VX_NUM_WARPS     = 4;
  localparam int unsigned VX_UUID_WIDTH    = 44;
  localparam int unsigned VX_CSR_ADDR_BITS = 12;

  // Extension CSR windows; END is one past the last address of the window.
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_TEX_BEGIN    = 12'hFC0;
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_TEX_END      = 12'hFC8;
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_RASTER_BEGIN = 12'hFC8;
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_RASTER_END   = 12'hFD0;
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_ROP_BEGIN    = 12'hFD0;
  localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_ROP_END      = 12'hFD8;

  // Default window size; the last index of a window is the COMMIT register.
  localparam int unsigned VX_SFU_CSR_COUNT      = 8;
  localparam int unsigned VX_SFU_CSR_COMMIT_IDX = VX_SFU_CSR_COUNT - 1;

  // Commit status word: pending flag at bit 8, commit count in bits 7:0.
  localparam int unsigned CSR_STATUS_PENDING_BIT = 8;
  localparam int unsigned CSR_STATUS_COUNT_W     = 8;

  typedef struct packed {
    logic [22:0]                   rsvd;
    logic                          pending;
    logic [CSR_STATUS_COUNT_W-1:0] count;
  } csr_status_t;

  function automatic logic [31:0] csr_status_word(input logic pending,
                                                  input logic [CSR_STATUS_COUNT_W-1:0] count);
    csr_status_t s;
    s.rsvd    = '0;
    s.pending = pending;
    s.count   = count;
    return s;
  endfunction

endpackage

// File: rtl/vx_sfu_csr_bank.sv
// One warp's CSR state: shadow bank, active bank, pending commit and commit count.
module vx_sfu_csr_bank
  import vx_sfu_csr_pkg::*;
#(
  parameter int unsigned NUM_DATA = 7,
  parameter int unsigned IDX_W    = VX_CSR_ADDR_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [31:0]                    wr_data,
  input  logic                           commit,
  input  logic                           lock,
  output logic [NUM_DATA*32-1:0]         shadow_o,
  output logic [NUM_DATA*32-1:0]         active_o,
  output logic                           pending_o,
  output logic [CSR_STATUS_COUNT_W-1:0]  ccount_o,
  output logic                           applied_o
);

  logic [NUM_DATA*32-1:0]        shadow_q, shadow_d;
  logic [NUM_DATA*32-1:0]        active_q, active_d;
  logic                          pending_q, pending_d;
  logic [CSR_STATUS_COUNT_W-1:0] ccount_q, ccount_d;
  logic                          applied_q, applied_d;
  logic                          apply;

  assign apply = pending_q & ~lock;

  // Shadow writes, commit arming and the shadow-to-active apply.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    ccount_d  = ccount_q;
    applied_d = 1'b0;

    for (int unsigned i = 0; i < NUM_DATA; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        shadow_d[i*32 +: 32] = wr_data;
      end
    end

    // A commit that lands on the apply edge merges into that apply: the
    // shadow being copied is already the newest, so nothing is lost.
    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ccount_d  = ccount_q + 1'b1;
      applied_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ccount_q  <= '0;
      applied_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ccount_q  <= ccount_d;
      applied_q <= applied_d;
    end
  end

  assign shadow_o  = shadow_q;
  assign active_o  = active_q;
  assign pending_o = pending_q;
  assign ccount_o  = ccount_q;
  assign applied_o = applied_q;

endmodule

// File: rtl/vx_sfu_csr_responder.sv
// CSR slave for one SFU extension window: decode, per-warp banks, read mux
// and the registered active-state response port.
module vx_sfu_csr_responder
  import vx_sfu_csr_pkg::*;
#(
  parameter int unsigned                  NUM_WARPS  = VX_NUM_WARPS,
  parameter int unsigned                  NUM_LANES  = 1,
  parameter logic [VX_CSR_ADDR_BITS-1:0]  CSR_BEGIN  = VX_CSR_TEX_BEGIN,
  parameter int unsigned                  NUM_CSRS   = VX_SFU_CSR_COUNT,
  parameter int unsigned                  PID_WIDTH  = 1,
  parameter int unsigned                  UUID_WIDTH = VX_UUID_WIDTH,
  parameter int unsigned                  NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          read_enable,
  input  logic [UUID_WIDTH-1:0]         read_uuid,
  input  logic [PID_WIDTH-1:0]          read_pid,
  input  logic [NW_WIDTH-1:0]           read_wid,
  input  logic [NUM_LANES-1:0]          read_tmask,
  input  logic [VX_CSR_ADDR_BITS-1:0]   read_addr,
  output logic [NUM_LANES*32-1:0]       read_data,

  input  logic                          write_enable,
  input  logic [UUID_WIDTH-1:0]         write_uuid,
  input  logic [PID_WIDTH-1:0]          write_pid,
  input  logic [NW_WIDTH-1:0]           write_wid,
  input  logic [NUM_LANES-1:0]          write_tmask,
  input  logic [VX_CSR_ADDR_BITS-1:0]   write_addr,
  input  logic [NUM_LANES*32-1:0]       write_data,

  input  logic                          state_req_valid,
  input  logic [NW_WIDTH-1:0]           state_req_wid,
  output logic                          state_rsp_valid,
  output logic [(NUM_CSRS-1)*32-1:0]    state_rsp_data,

  input  logic [NUM_WARPS-1:0]          state_lock,
  output logic [NUM_WARPS-1:0]          commit_mask
);

  localparam int unsigned NUM_DATA   = NUM_CSRS - 1;
  localparam int unsigned COMMIT_IDX = NUM_CSRS - 1;
  localparam int unsigned AW         = VX_CSR_ADDR_BITS;

  // Tags and packet ids are debug-only on this side.
  logic unused_req_tags;
  assign unused_req_tags = ^{read_uuid, read_pid, write_uuid, write_pid};

  // Window decode.
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_in_win, wr_in_win;
  logic          wr_is_commit, wr_is_data;

  assign rd_idx       = read_addr - CSR_BEGIN;
  assign wr_idx       = write_addr - CSR_BEGIN;
  assign rd_in_win    = (read_addr >= CSR_BEGIN) && (rd_idx < AW'(NUM_CSRS));
  assign wr_in_win    = (write_addr >= CSR_BEGIN) && (wr_idx < AW'(NUM_CSRS));
  assign wr_is_commit = wr_in_win && (wr_idx == AW'(COMMIT_IDX));
  assign wr_is_data   = wr_in_win && (wr_idx < AW'(NUM_DATA));

  // Lowest-indexed active lane supplies the write value.
  logic [31:0] wr_lane_data;
  logic        wr_lane_hit;

  // Priority encoder over write_tmask, lane 0 first.
  always_comb begin
    wr_lane_data = '0;
    wr_lane_hit  = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (write_tmask[l] && !wr_lane_hit) begin
        wr_lane_data = write_data[l*32 +: 32];
        wr_lane_hit  = 1'b1;
      end
    end
  end

  // Per-warp banks.
  logic [NUM_WARPS-1:0][NUM_DATA*32-1:0]        bank_shadow;
  logic [NUM_WARPS-1:0][NUM_DATA*32-1:0]        bank_active;
  logic [NUM_WARPS-1:0]                         bank_pending;
  logic [NUM_WARPS-1:0][CSR_STATUS_COUNT_W-1:0] bank_ccount;
  logic [NUM_WARPS-1:0]                         bank_applied;
  logic [NUM_WARPS-1:0]                         bank_wr_en;
  logic [NUM_WARPS-1:0]                         bank_commit;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    assign bank_wr_en[w]  = write_enable && wr_is_data && wr_lane_hit
                            && (write_wid == NW_WIDTH'(w));
    assign bank_commit[w] = write_enable && wr_is_commit
                            && (write_wid == NW_WIDTH'(w));

    vx_sfu_csr_bank #(
      .NUM_DATA (NUM_DATA),
      .IDX_W    (AW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en     (bank_wr_en[w]),
      .wr_idx    (wr_idx),
      .wr_data   (wr_lane_data),
      .commit    (bank_commit[w]),
      .lock      (state_lock[w]),
      .shadow_o  (bank_shadow[w]),
      .active_o  (bank_active[w]),
      .pending_o (bank_pending[w]),
      .ccount_o  (bank_ccount[w]),
      .applied_o (bank_applied[w])
    );
  end

  assign commit_mask = bank_applied;

  // Zero-latency read mux: select warp and register, then fan out per lane mask.
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (read_wid == NW_WIDTH'(w)) begin
        if (rd_idx == AW'(COMMIT_IDX)) begin
          rd_word = csr_status_word(bank_pending[w], bank_ccount[w]);
        end else begin
          for (int unsigned i = 0; i < NUM_DATA; i++) begin
            if (rd_idx == AW'(i)) begin
              rd_word = bank_shadow[w][i*32 +: 32];
            end
          end
        end
      end
    end

    read_data = '0;
    if (read_enable && rd_in_win) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (read_tmask[l]) begin
          read_data[l*32 +: 32] = rd_word;
        end
      end
    end
  end

  // State response: capture the requested warp's active bank (pre-apply value).
  logic                   state_rsp_valid_q, state_rsp_valid_d;
  logic [NUM_DATA*32-1:0] state_rsp_data_q, state_rsp_data_d;

  // Next-state for the response register.
  always_comb begin
    state_rsp_valid_d = state_req_valid;
    state_rsp_data_d  = state_rsp_data_q;
    if (state_req_valid) begin
      state_rsp_data_d = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (state_req_wid == NW_WIDTH'(w)) begin
          state_rsp_data_d = bank_active[w];
        end
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_rsp_valid_q <= 1'b0;
      state_rsp_data_q  <= '0;
    end else begin
      state_rsp_valid_q <= state_rsp_valid_d;
      state_rsp_data_q  <= state_rsp_data_d;
    end
  end

  assign state_rsp_valid = state_rsp_valid_q;
  assign state_rsp_data  = state_rsp_data_q;

endmodule
